// File: rtl/weight_stream_mem_pkg.sv
// Shared state encoding, skid depth and lane-slice helper for the multi-bank weight store.
`ifndef WEIGHT_STREAM_MEM_PKG_SV
`define WEIGHT_STREAM_MEM_PKG_SV

`define WSM_LANE(n, w) ((n) * (w)) +: (w)

package weight_stream_mem_pkg;
  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_READY  = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  localparam int SKID_DEPTH = 2;
endpackage

`endif

// File: rtl/weight_stream_mem_bank.sv
// One neuron's weight bank: simple dual-port RAM, synchronous write, registered read.
module weight_bank #(
  parameter int DEPTH      = 784,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_wen,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_ren,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_wen) r_mem[i_waddr] <= i_wdata;
    if (i_ren) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/weight_stream_mem.sv
// Multi-neuron weight store: stream-loaded neuron-major, replayed in lock-step as a
// backpressurable stream with a 2-entry skid buffer behind the 1-cycle bank read.
//
// state    | meaning
// S_LOAD   | accepting load words into bank[ncnt][wcnt]
// S_READY  | all banks filled, waiting for rd_start or ld_clear
// S_STREAM | replaying addresses 0..NUM_WEIGHTS-1 across all banks
module weight_stream_mem
  import weight_stream_mem_pkg::*;
#(
  parameter int NUM_NEURONS = 4,
  parameter int NUM_WEIGHTS = 784,
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = $clog2(NUM_WEIGHTS),
  parameter int NID_WIDTH   = $clog2(NUM_NEURONS) + 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              ld_valid,
  output logic                              ld_ready,
  input  logic [DATA_WIDTH-1:0]             ld_data,
  input  logic                              ld_last,
  input  logic                              ld_clear,
  output logic                              ld_err,
  output logic                              loaded,
  input  logic                              rd_start,
  output logic                              rd_valid,
  input  logic                              rd_ready,
  output logic [NUM_NEURONS*DATA_WIDTH-1:0] rd_data,
  output logic                              rd_last,
  output logic                              rd_done
);
  localparam int                    BUS_W     = NUM_NEURONS * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WEIGHTS - 1);
  localparam logic [NID_WIDTH-1:0]  LAST_NID  = NID_WIDTH'(NUM_NEURONS - 1);

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_wcnt, r_raddr;
  logic [NID_WIDTH-1:0]  r_ncnt;
  logic                  r_err, r_issue_done, r_inflight, r_inflight_last, r_done;
  logic [1:0]            r_cnt;
  logic [BUS_W-1:0]      r_buf0, r_buf1;
  logic                  r_last0, r_last1;
  logic [BUS_W-1:0]      w_bank_dout;
  logic                  w_accept, w_wlast, w_clear, w_start, w_pop, w_issue;
  logic [1:0]            w_occ;

  assign ld_ready = (r_state == S_LOAD);
  assign loaded   = (r_state != S_LOAD);
  assign ld_err   = r_err;
  assign rd_valid = (r_cnt != 2'd0);
  assign rd_data  = r_buf0;
  assign rd_last  = rd_valid && r_last0;
  assign rd_done  = r_done;

  // A load word coinciding with ld_clear is dropped: the clear restarts the frame.
  assign w_clear  = ld_clear && (r_state != S_STREAM);
  assign w_accept = ld_valid && ld_ready && !ld_clear;
  assign w_wlast  = (r_wcnt == LAST_ADDR);
  assign w_start  = (r_state == S_READY) && rd_start && !ld_clear;
  assign w_pop    = rd_valid && rd_ready;
  // Occupancy after this cycle's pop, so a steady ready stream never bubbles.
  assign w_occ    = r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
  assign w_issue  = (r_state == S_STREAM) && !r_issue_done && (w_occ < 2'(SKID_DEPTH));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_LOAD;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:   if (w_accept && w_wlast && (r_ncnt == LAST_NID)) w_state_nxt = S_READY;
      S_READY:  if (ld_clear) w_state_nxt = S_LOAD;
                else if (rd_start) w_state_nxt = S_STREAM;
      S_STREAM: if (w_pop && r_last0) w_state_nxt = S_READY;
      default:  w_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || w_clear) begin
      r_wcnt <= '0;
      r_ncnt <= '0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      if (ld_last != w_wlast) r_err <= 1'b1;
      if (w_wlast) begin
        r_wcnt <= '0;
        r_ncnt <= r_ncnt + NID_WIDTH'(1);
      end else begin
        r_wcnt <= r_wcnt + ADDR_WIDTH'(1);
      end
    end
  end

  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_bank
    weight_bank #(
      .DEPTH      (NUM_WEIGHTS),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank (
      .clk     (clk),
      .i_wen   (w_accept && (r_ncnt == NID_WIDTH'(n))),
      .i_waddr (r_wcnt),
      .i_wdata (ld_data),
      .i_ren   (w_issue),
      .i_raddr (r_raddr),
      .o_rdata (w_bank_dout[`WSM_LANE(n, DATA_WIDTH)])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_raddr         <= '0;
      r_issue_done    <= 1'b0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && (r_raddr == LAST_ADDR);
      if (w_start) begin
        r_raddr      <= '0;
        r_issue_done <= 1'b0;
      end else if (w_issue) begin
        if (r_raddr == LAST_ADDR) begin
          r_raddr      <= '0;
          r_issue_done <= 1'b1;
        end else begin
          r_raddr <= r_raddr + ADDR_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= 2'd0;
      r_buf0  <= '0;
      r_buf1  <= '0;
      r_last0 <= 1'b0;
      r_last1 <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_pop && r_last0;
      case ({r_inflight, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) begin
            r_buf0  <= w_bank_dout;
            r_last0 <= r_inflight_last;
          end else begin
            r_buf1  <= w_bank_dout;
            r_last1 <= r_inflight_last;
          end
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_buf0  <= r_buf1;
          r_last0 <= r_last1;
          r_cnt   <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_buf0  <= w_bank_dout;
            r_last0 <= r_inflight_last;
          end else begin
            r_buf0  <= r_buf1;
            r_last0 <= r_last1;
            r_buf1  <= w_bank_dout;
            r_last1 <= r_inflight_last;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_weight_stream_mem.sv
// Scoreboard bench for weight_stream_mem with 2 neurons x 4 weights.
module tb_weight_stream_mem;
  localparam int NN = 2;
  localparam int NW = 4;
  localparam int DW = 16;
  localparam int BW = NN * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ld_valid = 1'b0, ld_last = 1'b0, ld_clear = 1'b0;
  logic          rd_start = 1'b0, rd_ready = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_ready, ld_err, loaded, rd_valid, rd_last, rd_done;
  logic [BW-1:0] rd_data;

  int            n_vec = 0;
  int            n_err = 0;
  int            n_beats = 0;
  logic [BW:0]   exp_q[$];
  logic [BW:0]   mon_exp;
  logic [BW:0]   held;
  logic          stall_prev = 1'b0;
  logic [15:0]   pat;

  always #5 clk = ~clk;

  weight_stream_mem #(
    .NUM_NEURONS (NN),
    .NUM_WEIGHTS (NW),
    .DATA_WIDTH  (DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .ld_clear (ld_clear),
    .ld_err   (ld_err),
    .loaded   (loaded),
    .rd_start (rd_start),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_last  (rd_last),
    .rd_done  (rd_done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks that stalled beats hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        chk("stall_hold", 64'({rd_valid, rd_last, rd_data}), 64'({1'b1, held}));
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got 0x%0h, want no beat", {rd_last, rd_data});
        end else begin
          mon_exp = exp_q.pop_front();
          chk("beat", 64'({rd_last, rd_data}), 64'(mon_exp));
          n_beats++;
        end
      end
      stall_prev = rd_valid && !rd_ready;
      held       = {rd_last, rd_data};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load8(input logic [DW-1:0] base, input logic [7:0] lastm);
    for (int i = 0; i < 8; i++) begin
      ld_valid = 1'b1;
      ld_data  = base + DW'(i);
      ld_last  = lastm[i[2:0]];
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // Lane 0 = neuron 0 word k (base+k), lane 1 = neuron 1 word k (base+NW+k).
  task automatic push_exp(input logic [DW-1:0] base);
    logic [BW:0] e;
    for (int k = 0; k < NW; k++) begin
      e = {(k == NW - 1), base + DW'(NW + k), base + DW'(k)};
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
  endtask

  task automatic wait_done(input bit use_pat, output int cyc);
    cyc = 0;
    while (cyc < 200) begin
      if (use_pat) rd_ready = pat[cyc[3:0]];
      tick();
      cyc++;
      if (rd_done) break;
    end
    rd_ready = 1'b1;
    if (!rd_done) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got no rd_done in %0d cycles, want a pulse", cyc);
    end else begin
      chk("queue_drained", 64'(exp_q.size()), 64'(0));
      tick();
      chk("done_one_cycle", 64'(rd_done), 64'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end

  initial begin
    int cyc;
    int base;
    int k;
    pat = 16'b0110_1001_1100_1010;

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_ld_ready", 64'(ld_ready), 64'(1));
    chk("rst_loaded",   64'(loaded),   64'(0));
    chk("rst_ld_err",   64'(ld_err),   64'(0));
    chk("rst_rd_valid", 64'(rd_valid), 64'(0));
    chk("rst_rd_last",  64'(rd_last),  64'(0));
    chk("rst_rd_done",  64'(rd_done),  64'(0));
    chk("rst_rd_data",  64'(rd_data),  64'(0));
    rst_n = 1'b1;
    tick();

    // Clean load of words 1..8, ld_last on words 4 and 8
    load8(16'd1, 8'b1000_1000);
    chk("load_loaded",   64'(loaded),   64'(1));
    chk("load_ld_ready", 64'(ld_ready), 64'(0));
    chk("load_ld_err",   64'(ld_err),   64'(0));

    // Full-rate stream: first beat two cycles after rd_start, then back-to-back
    rd_ready = 1'b1;
    push_exp(16'd1);
    pulse_start();
    chk("lat_t1", 64'(rd_valid), 64'(0));
    tick();
    chk("lat_t2", 64'(rd_valid), 64'(0));
    tick();
    chk("lat_first_beat", 64'({rd_valid, rd_data}), 64'({1'b1, 16'd5, 16'd1}));
    wait_done(1'b0, cyc);
    chk("done_latency", 64'(cyc), 64'(4));
    chk("ready_after_stream", 64'({loaded, ld_ready}), 64'(2'b10));

    // Backpressured stream
    push_exp(16'd1);
    rd_ready = 1'b0;
    pulse_start();
    wait_done(1'b1, cyc);

    // rd_start and ld_clear together: clear wins
    rd_ready = 1'b1;
    rd_start = 1'b1;
    ld_clear = 1'b1;
    tick();
    rd_start = 1'b0;
    ld_clear = 1'b0;
    chk("clr_loaded",   64'(loaded),   64'(0));
    chk("clr_ld_ready", 64'(ld_ready), 64'(1));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("clr_no_beat", 64'(rd_valid), 64'(0));
    end

    // Framing error: extra ld_last on word 2; load still completes
    load8(16'h100, 8'b1000_1010);
    chk("err_set",    64'(ld_err), 64'(1));
    chk("err_loaded", 64'(loaded), 64'(1));
    push_exp(16'h100);
    pulse_start();
    wait_done(1'b0, cyc);
    chk("err_sticky", 64'(ld_err), 64'(1));
    ld_clear = 1'b1;
    tick();
    ld_clear = 1'b0;
    chk("err_cleared",  64'(ld_err),   64'(0));
    chk("err_unloaded", 64'(loaded),   64'(0));
    chk("err_ld_ready", 64'(ld_ready), 64'(1));

    // Reset during beat 2 of a stream
    load8(16'h20, 8'b1000_1000);
    push_exp(16'h20);
    pulse_start();
    base = n_beats;
    k = 0;
    while (n_beats == base && k < 20) begin
      tick();
      k++;
    end
    chk("mid_beat2", 64'({rd_valid, rd_data}), 64'({1'b1, 16'h25, 16'h21}));
    rst_n = 1'b0;
    tick();
    chk("mid_rst_rd_valid", 64'(rd_valid), 64'(0));
    chk("mid_rst_ld_ready", 64'(ld_ready), 64'(1));
    chk("mid_rst_loaded",   64'(loaded),   64'(0));
    rst_n = 1'b1;
    exp_q.delete();
    pulse_start();
    repeat (4) tick();
    chk("start_ignored_valid", 64'(rd_valid), 64'(0));
    chk("start_ignored_ready", 64'(ld_ready), 64'(1));

    // Recovery after reload
    load8(16'h40, 8'b1000_1000);
    push_exp(16'h40);
    pulse_start();
    wait_done(1'b0, cyc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/weight_stream_mem.md
Name: weight_stream_mem

Overview:
- Parametrised multi-neuron weight store for a fully-connected layer.
- Holds NUM_NEURONS banks of NUM_WEIGHTS words each, loaded at runtime over a valid/ready stream, neuron-major.
- Replays all banks in lock-step as a backpressurable stream: one beat carries weight k of every neuron, feeding the parallel neuron MAC array.
- Successor to the single-neuron weight memory: adds multi-bank width, a sequencing FSM, a handshake on both sides, load framing checks and a read skid buffer.

Parameters:
NUM_NEURONS, 4, number of banks (neurons served in parallel), >=1
NUM_WEIGHTS, 784, words per bank, >=2
DATA_WIDTH, 16, bits per weight
ADDR_WIDTH, $clog2(NUM_WEIGHTS), bank address width
NID_WIDTH, $clog2(NUM_NEURONS)+1, neuron counter width

Ports:
clk  in  1  single clock, all logic on posedge
rst_n  in  1  synchronous active-low reset
ld_valid  in  1  load word valid
ld_ready  out  1  load word accepted when ld_valid&&ld_ready
ld_data  in  DATA_WIDTH  weight word
ld_last  in  1  marks final word of the current neuron
ld_clear  in  1  pulse: invalidate contents, restart load
ld_err  out  1  sticky framing error
loaded  out  1  all banks filled
rd_start  in  1  pulse: begin one full replay
rd_valid  out  1  output beat valid
rd_ready  in  1  consumer accepts beat
rd_data  out  NUM_NEURONS*DATA_WIDTH  lane n = bank n word, lane 0 in LSBs
rd_last  out  1  beat carries address NUM_WEIGHTS-1
rd_done  out  1  one-cycle pulse after the last beat handshakes

Behaviour:
- Reset (rst_n=0 at posedge): state S_LOAD; wcnt=0, ncnt=0; ld_ready=1 on the following cycle; ld_err=0, loaded=0, rd_valid=0, rd_last=0, rd_done=0, rd_data=0; skid buffer emptied. Bank contents are not cleared.
- S_LOAD:
  - ld_ready=1. Each accepted word is written to bank[ncnt][wcnt].
  - wcnt increments. At wcnt=NUM_WEIGHTS-1 it wraps to 0 and ncnt increments.
  - ld_last asserted with wcnt!=NUM_WEIGHTS-1, or deasserted with wcnt==NUM_WEIGHTS-1: set ld_err. The word is still written and counting is unaffected; ld_last never realigns the counters.
  - Accepting word (NUM_NEURONS-1, NUM_WEIGHTS-1) moves to S_READY. loaded=1 and ld_ready=0 from the next cycle.
  - rd_start is ignored in this state.
- S_READY:
  - rd_start moves to S_STREAM with raddr=0.
  - ld_clear moves to S_LOAD and sets loaded=0, wcnt=ncnt=0, ld_err=0.
  - If both are asserted in the same cycle, ld_clear wins.
- ld_clear in S_LOAD restarts counting from 0 and clears ld_err. ld_clear in S_STREAM is ignored.
- S_STREAM, read path:
  - Banks have synchronous 1-cycle read latency.
  - A read of raddr issues only when (skid occupancy + reads in flight) < 2. raddr then increments. Issuing stops after NUM_WEIGHTS-1.
  - rd_start at edge T: first read issues at T+1, rd_valid=1 with address-0 data at T+2.
  - With rd_ready held high, throughput is 1 beat/cycle with no bubbles.
  - rd_ready low holds rd_data, rd_valid and rd_last stable. No beat is lost or duplicated.
  - rd_last=1 only on the address NUM_WEIGHTS-1 beat.
  - On handshake of that beat: rd_done=1 for one cycle, state returns to S_READY. rd_valid=0 unless a new beat is present.
  - rd_start while in S_STREAM is ignored.
- Reset mid-stream or mid-load: immediate return to the reset state. In-flight reads are discarded and rd_valid=0 next cycle.
- Widths: counters saturate-free with wrap exactly at NUM_WEIGHTS-1. No arithmetic on data.

Decomposition:
- Shared package/include: state encodings S_LOAD=2'd0, S_READY=2'd1, S_STREAM=2'd2, plus the lane-slice macro used for rd_data packing.
- Sub-module weight_bank: one per neuron via generate. Simple dual-port, sync write with wen, sync registered read with ren, depth NUM_WEIGHTS.
- The 2-entry skid buffer stays inline.

Test Plan:
- Load NUM_NEURONS=2, NUM_WEIGHTS=4 with words 1..8, ld_last on words 4 and 8 -> loaded=1 the cycle after word 8; ld_err=0; ld_ready=0.
- rd_start with rd_ready=1 -> beats start 2 cycles later, back-to-back: {2,1}? No: lane0=1..4, lane1=5..8, giving {5,1},{6,2},{7,3},{8,4}. rd_last on beat 4; rd_done the next cycle.
- Random rd_ready toggling (50%) -> same 4 beats in order, data stable while stalled, no duplicates.
- ld_last asserted on word 2 of neuron 0 -> ld_err=1 and stays 1; load still completes after 8 words; ld_clear drops ld_err and loaded.
- rst_n=0 during beat 2 of a stream -> rd_valid=0 next cycle, state S_LOAD, ld_ready=1; rd_start ignored until reload.
- rd_start and ld_clear in the same cycle in S_READY -> no beats; loaded=0; ld_ready=1.
